// File: rtl/io_poller.sv
// Second bus master that polls the switch register, debounces the value and
// mirrors each newly accepted value onto the LEDs and the two 7-segment displays.
module io_poller #(
  parameter int unsigned POLL_DIV      = 50000,
  parameter int unsigned STABLE_COUNT  = 3,
  parameter logic [31:0] SWITCHES_ADDR = 32'h0000_1000,
  parameter logic [31:0] LEDS_ADDR     = 32'h0000_1004,
  parameter logic [31:0] SEG1_ADDR     = 32'h0000_1008,
  parameter logic [31:0] SEG2_ADDR     = 32'h0000_100C
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        we,
  output logic [31:0] a,
  output logic [31:0] wd,
  output logic [2:0]  funct3,
  input  logic [31:0] rd,
  output logic        busy,
  output logic [3:0]  sw_value,
  output logic [7:0]  update_count
);

  localparam int unsigned     TW        = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [TW-1:0]   TIMER_MAX = TW'(POLL_DIV - 1);
  localparam logic [3:0]      STABLE_TH = 4'(STABLE_COUNT);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_EVAL    = 3'd2;
  localparam logic [2:0] S_WR_LEDS = 3'd3;
  localparam logic [2:0] S_WR_SEG1 = 3'd4;
  localparam logic [2:0] S_WR_SEG2 = 3'd5;

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic          tick;
  logic [3:0]    sample;
  logic [3:0]    prev;
  logic [3:0]    stable_cnt;
  logic [3:0]    stable_next;
  logic          valid;
  logic          commit;
  logic [3:0]    units;
  logic [3:0]    tens;

  function automatic logic [6:0] seg(input logic [3:0] digit);
    case (digit)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  endfunction

  assign tick = enable && (timer == TIMER_MAX);

  // sw_value never exceeds 15, so the tens digit is 0 or 1.
  assign units = (sw_value >= 4'd10) ? sw_value - 4'd10 : sw_value;
  assign tens  = (sw_value >= 4'd10) ? 4'd1 : 4'd0;

  assign stable_next = (sample != prev)      ? 4'd1 :
                       (stable_cnt == 4'hF)  ? 4'hF : stable_cnt + 4'd1;
  assign commit      = (stable_next >= STABLE_TH) && (!valid || sample != sw_value);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (!enable || timer == TIMER_MAX) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      sample       <= 4'd0;
      prev         <= 4'd0;
      stable_cnt   <= 4'd0;
      valid        <= 1'b0;
      sw_value     <= 4'd0;
      update_count <= 8'd0;
    end else begin
      case (state)
        S_IDLE: if (tick) state <= S_READ;
        S_READ: begin
          sample <= rd[3:0];
          state  <= S_EVAL;
        end
        S_EVAL: begin
          stable_cnt <= stable_next;
          prev       <= sample;
          if (commit) begin
            sw_value <= sample;
            valid    <= 1'b1;
            state    <= S_WR_LEDS;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WR_LEDS: state <= S_WR_SEG1;
        S_WR_SEG1: state <= S_WR_SEG2;
        S_WR_SEG2: begin
          update_count <= update_count + 8'd1;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    we = 1'b0;
    a  = 32'd0;
    wd = 32'd0;
    case (state)
      S_READ:    a = SWITCHES_ADDR;
      S_WR_LEDS: begin
        we = 1'b1;
        a  = LEDS_ADDR;
        wd = {28'd0, sw_value};
      end
      S_WR_SEG1: begin
        we = 1'b1;
        a  = SEG1_ADDR;
        wd = {25'd0, seg(units)};
      end
      S_WR_SEG2: begin
        we = 1'b1;
        a  = SEG2_ADDR;
        wd = {25'd0, seg(tens)};
      end
      default: ;
    endcase
  end

  assign funct3 = 3'b010;
  assign busy   = (state != S_IDLE);

endmodule
